// File: rtl/tuner_ts_pkg.sv
// Shared TS constants and write-side FSM encoding for the tuner front end.
package tuner_ts_pkg;

  localparam int         TS_PKT_LEN     = 188;
  localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
  localparam int         PSEUDO_HDR_LEN = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    FILL    = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ts_pkt_ram.sv
// Byte-wide simple dual-port RAM with a registered read port; contents are never reset.
module ts_pkt_ram #(
  parameter int DEPTH = 752,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ts_packet_buffer.sv
// Per-tuner TS packet buffer: sync hunt, slot storage of whole packets, one-packet replay.
// Optional drop/short-packet statistics ports are enabled by defining TS_BUF_STATS_EN.
module ts_packet_buffer
  import tuner_ts_pkg::*;
#(
  parameter int PKT_SLOTS = 4
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic [7:0] DATA_IN,
  input  logic       D_VALID_IN,
  input  logic       P_SYNC_IN,
  input  logic       GIVE_ME_ONE_PACKET,
  output logic       GOT_FULL_PACKET,
  output logic [7:0] DATA_OUT
`ifdef TS_BUF_STATS_EN
  ,
  output logic [15:0] DROP_CNT,
  output logic [15:0] SHORT_CNT
`endif
);

  localparam int DEPTH = PKT_SLOTS * TS_PKT_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(PKT_SLOTS);
  localparam int CW    = $clog2(PKT_SLOTS + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(PKT_SLOTS - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(TS_PKT_LEN - 1);

  wr_state_e     r_state, w_state_nxt;
  logic [SW-1:0] r_wr_slot, r_rd_slot;
  logic [7:0]    r_byte_idx, w_byte_idx_nxt, w_widx, r_rd_idx;
  logic [CW-1:0] r_pkt_count, w_pkt_count_nxt;
  logic          r_rd_active, r_dvld, r_got_full;
  logic          w_start, w_free, w_we, w_commit, w_drop, w_short, w_accept, w_rd_last;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [7:0]    w_ram_q;

  assign w_start   = D_VALID_IN && P_SYNC_IN && (DATA_IN == TS_SYNC_BYTE);
  // The slot being replayed still counts as occupied until its last byte leaves.
  assign w_free    = (int'(r_pkt_count) + int'(r_rd_active)) < PKT_SLOTS;
  assign w_accept  = GIVE_ME_ONE_PACKET && (r_pkt_count != '0) && !r_rd_active;
  assign w_rd_last = r_rd_active && (r_rd_idx == LAST_IDX);

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_widx         = r_byte_idx;
    w_we           = 1'b0;
    w_commit       = 1'b0;
    w_drop         = 1'b0;
    w_short        = (r_state == FILL) && D_VALID_IN && P_SYNC_IN;
    if (w_start) begin
      if (w_free) begin
        w_we           = 1'b1;
        w_widx         = 8'd0;
        w_byte_idx_nxt = 8'd1;
        w_state_nxt    = FILL;
      end else begin
        w_drop      = 1'b1;
        w_state_nxt = DISCARD;
      end
    end else if (r_state == FILL && D_VALID_IN) begin
      if (P_SYNC_IN) begin
        w_state_nxt = HUNT;
      end else begin
        w_we           = 1'b1;
        w_byte_idx_nxt = r_byte_idx + 8'd1;
        if (r_byte_idx == LAST_IDX) begin
          w_commit    = 1'b1;
          w_state_nxt = HUNT;
        end
      end
    end
  end

  always_comb begin
    w_pkt_count_nxt = r_pkt_count;
    case ({w_commit, w_accept})
      2'b10:   w_pkt_count_nxt = r_pkt_count + 1'b1;
      2'b01:   w_pkt_count_nxt = r_pkt_count - 1'b1;
      default: w_pkt_count_nxt = r_pkt_count;
    endcase
  end

  assign w_waddr = AW'(int'(r_wr_slot) * TS_PKT_LEN + int'(w_widx));
  assign w_raddr = AW'(int'(r_rd_slot) * TS_PKT_LEN + int'(r_rd_idx));

  ts_pkt_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (SYS_CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (DATA_IN),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge SYS_CLK) begin
    if (!RST) begin
      r_state     <= HUNT;
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_byte_idx  <= '0;
      r_rd_idx    <= '0;
      r_pkt_count <= '0;
      r_rd_active <= 1'b0;
      r_dvld      <= 1'b0;
      r_got_full  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_pkt_count <= w_pkt_count_nxt;
      r_got_full  <= (w_pkt_count_nxt != '0);
      // RAM output lags the read address by one edge; qualify it the same way.
      r_dvld      <= r_rd_active;
      if (w_commit) r_wr_slot <= (r_wr_slot == LAST_SLOT) ? '0 : r_wr_slot + 1'b1;
      if (w_accept) begin
        r_rd_active <= 1'b1;
        r_rd_idx    <= '0;
      end else if (w_rd_last) begin
        r_rd_active <= 1'b0;
        r_rd_slot   <= (r_rd_slot == LAST_SLOT) ? '0 : r_rd_slot + 1'b1;
      end else if (r_rd_active) begin
        r_rd_idx <= r_rd_idx + 8'd1;
      end
    end
  end

  assign GOT_FULL_PACKET = r_got_full;
  assign DATA_OUT        = r_dvld ? w_ram_q : 8'h00;

`ifdef TS_BUF_STATS_EN
  logic [15:0] r_drop_cnt, r_short_cnt;
  always_ff @(posedge SYS_CLK) begin
    if (!RST) begin
      r_drop_cnt  <= '0;
      r_short_cnt <= '0;
    end else begin
      if (w_drop)  r_drop_cnt  <= sat_inc16(r_drop_cnt);
      if (w_short) r_short_cnt <= sat_inc16(r_short_cnt);
    end
  end
  assign DROP_CNT  = r_drop_cnt;
  assign SHORT_CNT = r_short_cnt;
`endif

endmodule

// File: tb/tb_ts_packet_buffer.sv
// Directed bench for ts_packet_buffer: store, replay, short/overflow/in-replay drops, reset abort.
module tb_ts_packet_buffer;

  logic       SYS_CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       D_VALID_IN = 1'b0;
  logic       P_SYNC_IN = 1'b0;
  logic       GIVE_ME_ONE_PACKET = 1'b0;
  logic       GOT_FULL_PACKET;
  logic [7:0] DATA_OUT;
`ifdef TS_BUF_STATS_EN
  logic [15:0] DROP_CNT, SHORT_CNT;
`endif

  int total = 0;
  int bad   = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  ts_packet_buffer #(.PKT_SLOTS(4)) dut (
    .SYS_CLK            (SYS_CLK),
    .RST                (RST),
    .DATA_IN            (DATA_IN),
    .D_VALID_IN         (D_VALID_IN),
    .P_SYNC_IN          (P_SYNC_IN),
    .GIVE_ME_ONE_PACKET (GIVE_ME_ONE_PACKET),
    .GOT_FULL_PACKET    (GOT_FULL_PACKET),
    .DATA_OUT           (DATA_OUT)
`ifdef TS_BUF_STATS_EN
    ,
    .DROP_CNT           (DROP_CNT),
    .SHORT_CNT          (SHORT_CNT)
`endif
  );

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input logic [7:0] base, input int n);
    return (n == 0) ? 8'h47 : 8'(int'(base) + n);
  endfunction

  // Byte 0 carries the sync marker; the remaining bytes are base+n.
  task automatic send_bytes(input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      D_VALID_IN = 1'b1;
      P_SYNC_IN  = (i == 0);
      DATA_IN    = pkt_byte(base, i);
      tick();
    end
    D_VALID_IN = 1'b0;
    P_SYNC_IN  = 1'b0;
    DATA_IN    = 8'h00;
  endtask

  // Accept a request, then check bytes 0..stop; mid pulses a request that must be ignored.
  task automatic replay(input logic [7:0] base, input logic flag_after, input int mid, input int stop);
    GIVE_ME_ONE_PACKET = 1'b1;
    tick();
    GIVE_ME_ONE_PACKET = 1'b0;
    check("flag_at_accept", 16'(GOT_FULL_PACKET), 16'(flag_after));
    check("out_idle_at_accept", 16'(DATA_OUT), 16'h0);
    for (int n = 0; n <= stop; n++) begin
      GIVE_ME_ONE_PACKET = (n == mid);
      tick();
      check($sformatf("replay_%02h_byte%0d", base, n), 16'(DATA_OUT), 16'(pkt_byte(base, n)));
    end
    GIVE_ME_ONE_PACKET = 1'b0;
    if (stop == 187) begin
      tick();
      check("out_zero_after_pkt", 16'(DATA_OUT), 16'h0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_flag", 16'(GOT_FULL_PACKET), 16'h0);
    check("rst_data", 16'(DATA_OUT), 16'h0);
    RST = 1'b1;
    tick();

    // Single packet: 0x47, 0x01..0xBB
    send_bytes(8'h00, 188);
    check("single_flag", 16'(GOT_FULL_PACKET), 16'h1);
    replay(8'h00, 1'b0, -1, 187);

    // Short packet followed by a full one: only the second is stored
    send_bytes(8'h10, 100);
    check("short_no_flag", 16'(GOT_FULL_PACKET), 16'h0);
    send_bytes(8'h20, 188);
    check("short_flag", 16'(GOT_FULL_PACKET), 16'h1);
`ifdef TS_BUF_STATS_EN
    check("short_cnt", SHORT_CNT, 16'd1);
`endif
    replay(8'h20, 1'b0, -1, 187);

    // Request at pkt_count=0 is ignored
    GIVE_ME_ONE_PACKET = 1'b1;
    tick();
    GIVE_ME_ONE_PACKET = 1'b0;
    check("empty_req_flag", 16'(GOT_FULL_PACKET), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_req_data", 16'(DATA_OUT), 16'h0);
    end

    // Overflow: fifth packet is dropped
    send_bytes(8'h30, 188);
    send_bytes(8'h40, 188);
    send_bytes(8'h50, 188);
    send_bytes(8'h60, 188);
    send_bytes(8'h70, 188);
    check("ovf_flag", 16'(GOT_FULL_PACKET), 16'h1);
`ifdef TS_BUF_STATS_EN
    check("ovf_drop_cnt", DROP_CNT, 16'd1);
`endif
    replay(8'h30, 1'b1, -1, 187);
    replay(8'h40, 1'b1, -1, 187);
    replay(8'h50, 1'b1, -1, 187);
    replay(8'h60, 1'b0, -1, 187);
    GIVE_ME_ONE_PACKET = 1'b1;
    tick();
    GIVE_ME_ONE_PACKET = 1'b0;
    tick();
    check("ovf_fifth_lost", 16'(DATA_OUT), 16'h0);

    // Packet arriving while the fourth slot is in replay is dropped; replay intact
    send_bytes(8'h80, 188);
    send_bytes(8'h90, 188);
    send_bytes(8'hA0, 188);
    send_bytes(8'hB0, 188);
    fork
      replay(8'h80, 1'b1, 50, 187);
      begin
        tick();
        send_bytes(8'hC0, 188);
      end
    join
`ifdef TS_BUF_STATS_EN
    check("inreplay_drop_cnt", DROP_CNT, 16'd2);
`endif
    replay(8'h90, 1'b1, -1, 187);
    replay(8'hA0, 1'b1, -1, 187);
    replay(8'hB0, 1'b0, -1, 187);

    // Reset at replay byte 90 aborts replay and clears the stored packet
    send_bytes(8'hD0, 188);
    send_bytes(8'hD8, 188);
    replay(8'hD0, 1'b1, -1, 90);
    RST = 1'b0;
    tick();
    check("abort_data", 16'(DATA_OUT), 16'h0);
    check("abort_flag", 16'(GOT_FULL_PACKET), 16'h0);
`ifdef TS_BUF_STATS_EN
    check("abort_drop_cnt", DROP_CNT, 16'd0);
    check("abort_short_cnt", SHORT_CNT, 16'd0);
`endif
    RST = 1'b1;
    tick();
    check("post_rst_data", 16'(DATA_OUT), 16'h0);
    send_bytes(8'hE0, 188);
    check("post_rst_flag", 16'(GOT_FULL_PACKET), 16'h1);
    replay(8'hE0, 1'b0, -1, 187);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ts_packet_buffer.md
# ts_packet_buffer

Per-tuner TS packet buffer that sits directly upstream of the four-input source switch, with one instance per tuner channel. It hunts for 0x47 sync bytes in the incoming byte stream and stores only complete 188-byte packets in a small slot memory. It advertises packet availability to the switch and, on a one-cycle request, replays exactly one packet at one byte per clock. The replay is timed so that the sync byte lands immediately after the switch's 4-byte pseudo-header.

## Interface
- PKT_SLOTS, 4, number of 188-byte packet slots (2..8); memory depth is PKT_SLOTS*188 bytes
- SYS_CLK  in  1  system clock; all logic is on its rising edge
- RST  in  1  reset, synchronous, active-low
- DATA_IN  in  8  TS byte from the tuner, already in the SYS_CLK domain
- D_VALID_IN  in  1  DATA_IN qualifier; one byte per cycle in which it is high
- P_SYNC_IN  in  1  packet-start marker; meaningful only when D_VALID_IN=1
- GIVE_ME_ONE_PACKET  in  1  read request from the switch; one-cycle pulse
- GOT_FULL_PACKET  out  1  at least one complete packet is stored and not yet requested
- DATA_OUT  out  8  replayed packet byte

## Operation
Write side: FSM with states HUNT, FILL and DISCARD.
- **Packet start.** Occurs when D_VALID_IN=1, P_SYNC_IN=1 and DATA_IN=8'h47.
  - If occupancy < PKT_SLOTS: write byte 0 into slot wr_slot, set byte_idx=1, go to FILL.
  - Otherwise: go to DISCARD and count one drop.
  - Occupancy = pkt_count + rd_active. This protects the slot currently being replayed.
- **HUNT.** Ignores all bytes except a packet start.
- **FILL.** On each valid byte without sync: write it at wr_slot*188+byte_idx, then increment byte_idx.
  - When byte 187 is written, the packet commits: wr_slot = (wr_slot+1) mod PKT_SLOTS, pkt_count+1, go to HUNT.
- **FILL, early sync.** A valid P_SYNC_IN before byte 187 means a short packet.
  - The current fill is abandoned with no commit.
  - If the byte is 0x47, the same slot restarts at byte 0 (free-slot test repeated). Otherwise the FSM returns to HUNT.
- **DISCARD.** Stays until the next packet start, which is evaluated exactly as in HUNT.

Read side:
- **Request accepted.** A GIVE_ME_ONE_PACKET sample is accepted when pkt_count != 0 and rd_active=0.
  - On acceptance: rd_active=1, rd_slot latched, rd_idx=0, pkt_count-1.
  - A request seen while pkt_count=0 or rd_active=1 is ignored.
- **Replay.** Emits bytes 0..187 of rd_slot, one per cycle, with no gaps.
  - After byte 187: rd_slot = (rd_slot+1) mod PKT_SLOTS, rd_active=0, DATA_OUT returns to 0.
- **Counter arithmetic.** pkt_count is $clog2(PKT_SLOTS+1) bits wide. If a commit and an acceptance occur in the same cycle, pkt_count is unchanged. pkt_count never exceeds PKT_SLOTS and never wraps below 0.
- **Availability flag.** GOT_FULL_PACKET is registered and equals (pkt_count_next != 0).

## Timing
- **Reset.** While RST=0 at a clock edge, the block is in reset.
  - Outputs: GOT_FULL_PACKET=0, DATA_OUT=0.
  - Internal state: FSM=HUNT, pointers=0, pkt_count=0, rd_active=0, drop counter=0.
  - Memory contents are not cleared.
  - A reset during FILL or replay aborts the operation; the partial packet is lost.
- **Replay latency.** If the request is sampled high at edge k, DATA_OUT holds byte n after edge k+1+n, for n=0..187.
  - Memory is a registered-output RAM: the read address is set at edge k and data is registered at edge k+1.
  - The switch, which asserts the request two cycles before its forward phase, therefore captures 0x47 on its first forward byte.
- **Commit to flag.** GOT_FULL_PACKET rises the cycle after the edge that writes byte 187.
- **Request to flag.** GOT_FULL_PACKET falls on the edge that accepts the request if pkt_count was 1.
- **Write-to-read bypass.** Not required: a slot is only readable after commit.

## Configuration
- Macro: TS_BUF_STATS_EN.
- **Defined.** Adds two ports:
  - DROP_CNT (out, 16): saturating count of packets dropped at a full buffer.
  - SHORT_CNT (out, 16): saturating count of FILL aborts caused by early sync.
  - Both reset to 0 and stick at 16'hFFFF.
- **Undefined.** The ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package tuner_ts_pkg holds:
  - TS_PKT_LEN=188 and TS_SYNC_BYTE=8'h47
  - the write-FSM state encoding (HUNT/FILL/DISCARD, 2 bits)
  - PSEUDO_HDR_LEN=4, shared with the switch
- Sub-module ts_pkt_ram: simple dual-port RAM, byte wide, one write port, one read port with registered output, depth parameterised.
- The FSM, pointers and counters live in ts_packet_buffer.

## Test plan
- **Single packet.** Feed 188 valid bytes starting 0x47, 0x01..0xBB with P_SYNC on byte 0, then pulse the request. Expect GOT_FULL_PACKET 1→0 and DATA_OUT = 0x47, 0x01..0xBB on consecutive cycles starting edge k+1, then 0.
- **Short packet.** Send 100 bytes, then a new sync packet of 188 bytes. Expect exactly one stored packet equal to the second; SHORT_CNT=1 when TS_BUF_STATS_EN is defined.
- **Overflow.** Write 5 packets with PKT_SLOTS=4 and no requests. Expect packets 1-4 replayed in order, packet 5 lost, DROP_CNT=1.
- **Slot in replay.** Fill 4 slots, request one, and during its replay send a full packet. Expect it to be dropped (occupancy 4) and the replay data to be uncorrupted.
- **Ignored requests.** Pulse the request at pkt_count=0, and again mid-replay. Expect no change to DATA_OUT or pkt_count.
- **Reset abort.** Drive RST low at replay byte 90. Expect DATA_OUT=0 and GOT_FULL_PACKET=0 on the next edge, and normal operation after release.
